// File: rtl/w_74hc_pkg.sv
// ============================================================================
// w_74hc_pkg : shared constants for the 74HC16x counter models
// Rev 1.0
// ============================================================================
`default_nettype none

package w_74hc_pkg;

    localparam int DEFAULT_WIDTH = 4;

    // Next-state selector encodings
    localparam int SEL_W = 3;
    typedef logic [SEL_W-1:0] sel_t;

    localparam sel_t SEL_CLR  = 3'd0;
    localparam sel_t SEL_LOAD = 3'd1;
    localparam sel_t SEL_INC  = 3'd2;
    localparam sel_t SEL_DEC  = 3'd3;
    localparam sel_t SEL_HOLD = 3'd4;

    // Terminal-count helpers
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;
    localparam int   TERM_DOWN_VALUE = 0;

    function automatic int term_value(input int modulus, input logic up);
        return up ? (modulus - 1) : TERM_DOWN_VALUE;
    endfunction

endpackage

`default_nettype wire

// File: rtl/w_74hc_cnt_next.sv
// ============================================================================
// w_74hc_cnt_next : next-state and terminal-value logic of the modulo-N counter
// Rev 1.0
// ============================================================================
`default_nettype none

module w_74hc_cnt_next
    import w_74hc_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    input  logic             ld_n,
    input  logic             enp,
    input  logic             ent,
    input  logic             up,
    output logic [WIDTH-1:0] q_next,
    output logic [WIDTH-1:0] terminal
);

    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_value(MODULUS, DIR_UP));
    localparam logic [WIDTH-1:0] TERM_DN = WIDTH'(term_value(MODULUS, DIR_DOWN));
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    sel_t sel;

    always_comb begin
        sel = SEL_HOLD;
        if (!ld_n) begin
            sel = SEL_LOAD;
        end else if (enp && ent) begin
            sel = up ? SEL_INC : SEL_DEC;
        end
    end

    // Wrap is an explicit compare, so out-of-range states recover in one count
    always_comb begin
        q_next = q;
        case (sel)
            SEL_LOAD: q_next = d;
            SEL_INC:  q_next = (q < TERM_UP) ? (q + ONE) : '0;
            SEL_DEC:  q_next = (q != '0 && q <= TERM_UP) ? (q - ONE) : TERM_UP;
            SEL_CLR:  q_next = '0;
            default:  q_next = q;
        endcase
    end

    assign terminal = up ? TERM_UP : TERM_DN;

endmodule

`default_nettype wire

// File: rtl/w_74hc161_counter.sv
// ============================================================================
// w_74hc161_counter : presettable synchronous modulo-N counter (74HC161/160)
// Optional up/down counting with U_D when W_74HC161_UPDOWN_EN is defined.
// Rev 1.0
// ============================================================================
`default_nettype none

module w_74hc161_counter
    import w_74hc_pkg::*;
#(
    parameter int WIDTH   = DEFAULT_WIDTH,
    parameter int MODULUS = 2 ** WIDTH
) (
    input  logic             CLK,
    input  logic             R,
    input  logic             LD,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
`ifdef W_74HC161_UPDOWN_EN
    input  logic             U_D,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    if (WIDTH < 2 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_param_check
        $error("w_74hc161_counter: WIDTH must be >= 2 and MODULUS in 2..2**WIDTH");
    end

    logic             count_up;
    logic [WIDTH-1:0] q_next;
    logic [WIDTH-1:0] terminal;

`ifdef W_74HC161_UPDOWN_EN
    assign count_up = U_D;
`else
    assign count_up = DIR_UP;
`endif

    w_74hc_cnt_next #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_next (
        .q        (Q),
        .d        (D),
        .ld_n     (LD),
        .enp      (ENP),
        .ent      (ENT),
        .up       (count_up),
        .q_next   (q_next),
        .terminal (terminal)
    );

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            Q <= '0;
        end else begin
            Q <= q_next;
        end
    end

    // Combinational so a cascaded stage sees the carry in the same cycle
    assign RCO = ENT & (Q == terminal);

endmodule

`default_nettype wire

// File: tb/tb_w_74hc161_counter.sv
// Testbench for w_74hc161_counter (WIDTH=4, MODULUS=10): directed plan plus random run.
`default_nettype none

module tb_w_74hc161_counter;

    localparam int WIDTH = 4;
    localparam int MOD   = 10;

    logic             clk = 1'b0;
    logic             r, ld, enp, ent, ud;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             rco;

    int checks   = 0;
    int failures = 0;
    int m        = 0;

    always #5 clk = ~clk;

    w_74hc161_counter #(.WIDTH(WIDTH), .MODULUS(MOD)) dut (
        .CLK (clk),
        .R   (r),
        .LD  (ld),
        .ENP (enp),
        .ENT (ent),
        .D   (d),
`ifdef W_74HC161_UPDOWN_EN
        .U_D (ud),
`endif
        .Q   (q),
        .RCO (rco)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic exp_rco();
        int term = ud ? MOD - 1 : 0;
        return ent && (m == term);
    endfunction

    // Reference behaviour at a rising edge, written from the counter's rules
    function automatic int model_next(input int cur);
        if (!r)          return 0;
        if (!ld)         return int'(d);
        if (!(enp && ent)) return cur;
        if (ud)          return (cur >= MOD - 1) ? 0 : cur + 1;
        return (cur == 0 || cur > MOD - 1) ? MOD - 1 : cur - 1;
    endfunction

    // Drive inputs away from the edge, check combinational state, then clock and recheck
    task automatic step(input string tag, input logic nr, input logic nld,
                        input logic nenp, input logic nent,
                        input logic [WIDTH-1:0] nd, input logic nud);
        r = nr; ld = nld; enp = nenp; ent = nent; d = nd; ud = nud;
        if (!r) m = 0;
        #1;
        check({tag, "_pre_q"}, 32'(q), 32'(m));
        check({tag, "_pre_rco"}, 32'(rco), 32'(exp_rco()));
        @(posedge clk);
        m = model_next(m);
        #1;
        check({tag, "_q"}, 32'(q), 32'(m));
        check({tag, "_rco"}, 32'(rco), 32'(exp_rco()));
    endtask

    initial begin
        r = 1'b0; ld = 1'b1; enp = 1'b1; ent = 1'b1; d = '0; ud = 1'b1;
        @(posedge clk);
        #1;
        check("reset_q", 32'(q), 32'd0);
        check("reset_rco", 32'(rco), 32'd0);

        // Decade count from 0: 1..9,0,1,2 with RCO only at 9
        for (int i = 0; i < 12; i++) begin
            step("count", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
            check("count_seq", 32'(q), 32'((i + 1) % MOD));
            check("count_rco9", 32'(rco), 32'(q == 4'd9));
        end

        step("to3", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
        check("at3", 32'(q), 32'd3);
        step("load7", 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 1'b1);
        check("load7_q", 32'(q), 32'd7);
        step("after7", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
        check("after7_q", 32'(q), 32'd8);

        step("load13", 1'b1, 1'b0, 1'b1, 1'b1, 4'd13, 1'b1);
        check("load13_q", 32'(q), 32'd13);
        check("load13_rco", 32'(rco), 32'd0);
        step("recover", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
        check("recover_q", 32'(q), 32'd0);

        for (int i = 0; i < 6; i++) step("to6", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
        check("at6", 32'(q), 32'd6);
        step("clr", 1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
        check("clr_hold", 32'(q), 32'd0);
        step("clr_rel", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b1);
        check("clr_rel_q", 32'(q), 32'd1);

        step("load9", 1'b1, 1'b0, 1'b0, 1'b0, 4'd9, 1'b1);
        step("ent0", 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b1);
        check("ent0_q", 32'(q), 32'd9);
        check("ent0_rco", 32'(rco), 32'd0);
        step("enp0", 1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 1'b1);
        check("enp0_q", 32'(q), 32'd9);
        check("enp0_rco", 32'(rco), 32'd1);

`ifdef W_74HC161_UPDOWN_EN
        step("load2", 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step("down", 1'b1, 1'b1, 1'b1, 1'b1, 4'd0, 1'b0);
            check("down_seq", 32'(q), 32'((i == 0) ? 1 : (i == 1) ? 0 : (i == 2) ? 9 : 8));
            check("down_rco", 32'(rco), 32'(q == 4'd0));
        end
`endif

        for (int i = 0; i < 400; i++) begin
            step("rand",
                 1'($urandom_range(0, 31) != 0),
                 1'($urandom_range(0, 7) != 0),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 3) != 0),
                 4'($urandom_range(0, 15)),
`ifdef W_74HC161_UPDOWN_EN
                 1'($urandom_range(0, 1))
`else
                 1'b1
`endif
                 );
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
